// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared word memory.
// The slave modport is the arbiter's view; the master modport is the
// requester/memory side.
interface mem_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
        output ack, rdata, mem_read, mem_write, mem_addr, mem_write_data
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ack, rdata, mem_read, mem_write, mem_addr, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single asynchronous
// word memory. Reads hold mem_read for READ_WAIT cycles before the data is
// registered; writes pulse mem_write for one cycle. Each access ends with a
// one-cycle ack to the port that was granted.
module mem_arbiter #(
    parameter int READ_WAIT = 3
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(READ_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic        grant;
    logic        last_grant;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        req_any;
    logic        grant_sel;

    // Pick the port to serve; on a tie the port not served last time wins.
    always_comb begin
        req_any   = |bus.req;
        grant_sel = 1'b0;
        case (bus.req)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant;
            default: grant_sel = 1'b0;
        endcase
    end

    // State register; reset drops straight to IDLE so mem_write falls at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic and the memory strobes / ack decoded from the state.
    always_comb begin
        state_next    = state;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.ack       = 2'b00;
        case (state)
            IDLE: begin
                if (req_any)
                    state_next = bus.we[grant_sel] ? WR : RD;
            end
            RD: begin
                bus.mem_read = 1'b1;
                if (cnt == 4'd0)
                    state_next = ACK;
            end
            WR: begin
                bus.mem_write = 1'b1;
                state_next    = ACK;
            end
            ACK: begin
                bus.ack    = grant ? 2'b10 : 2'b01;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant bookkeeping, request latching, wait counter and read capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant      <= grant_sel;
                        last_grant <= grant_sel;
                        addr_q     <= grant_sel ? bus.addr1  : bus.addr0;
                        wdata_q    <= grant_sel ? bus.wdata1 : bus.wdata0;
                        if (!bus.we[grant_sel])
                            cnt <= CNT_LOAD;
                    end
                end
                RD: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        rdata_q <= bus.mem_read_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.rdata          = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, round-robin contention, single read,
// write with read-back, reset abort during a write, and a READ_WAIT=1 instance.
module tb_mem_arbiter;

    logic clk;
    logic reset;

    mem_arbiter_if bus ();
    mem_arbiter_if bus2 ();

    mem_arbiter #(.READ_WAIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_arbiter #(.READ_WAIT(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    int checks = 0;
    int errors = 0;

    // Word memory model behind the main instance, with a bench preload port.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory write port: the arbiter's write strobe, or a bench preload.
    always @(posedge clk) begin
        if (bus.mem_write === 1'b1)
            mem[bus.mem_addr[9:2]] <= bus.mem_write_data;
        else if (pre_we)
            mem[pre_idx] <= pre_data;
    end

    assign bus.mem_read_data  = mem[bus.mem_addr[9:2]];
    assign bus2.mem_read_data = bus2.mem_addr ^ 32'h5A5A_A5A5;

    // Continuous safety checks: never both acks, never read and write together.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            assert (!(bus.ack === 2'b11) && !(bus.mem_read === 1'b1 && bus.mem_write === 1'b1))
            else begin
                errors++;
                $error("[TB] FAIL exclusive observed ack=%b rd=%b wr=%b expected no overlap",
                       bus.ack, bus.mem_read, bus.mem_write);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        bus.req    = r;
        bus.we     = w;
        bus.addr0  = a0;
        bus.addr1  = a1;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // One access on the main instance, started at a negedge with the FSM in IDLE.
    // lat counts negedges after the sampling posedge until ack is seen.
    task automatic run_access(input logic [1:0] r, input logic [1:0] w,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              output int lat, output int rd_cyc, output int wr_cyc,
                              output logic [1:0] ack_v, output logic [31:0] rd_v);
        lat    = 0;
        rd_cyc = 0;
        wr_cyc = 0;
        ack_v  = 2'b00;
        rd_v   = 32'd0;
        @(negedge clk);
        applyStimulus(r, w, a0, a1, d0, d1);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_read === 1'b1)  rd_cyc++;
            if (bus.mem_write === 1'b1) wr_cyc++;
            if (bus.ack !== 2'b00) begin
                ack_v = bus.ack;
                rd_v  = bus.rdata;
                break;
            end
        end
        checkOutput("ack_seen", {31'd0, ack_v !== 2'b00}, 32'd1);
        applyStimulus(2'b00, 2'b00, a0, a1, d0, d1);
    endtask

    int          lat;
    int          rd_cyc;
    int          wr_cyc;
    logic [1:0]  ack_v;
    logic [31:0] rd_v;
    logic [1:0]  req_hold;

    initial begin
        applyStimulus(2'b11, 2'b00, 32'h0000_00C8, 32'h0000_0104, 32'd0, 32'd0);
        bus2.req    = 2'b00;
        bus2.we     = 2'b00;
        bus2.addr0  = 32'h0000_0014;
        bus2.addr1  = 32'd0;
        bus2.wdata0 = 32'd0;
        bus2.wdata1 = 32'd0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset held with both ports requesting; preload the memory meanwhile.
        preload(8'h32, 32'hDEAD_BEEF);
        preload(8'h41, 32'hCAFE_F00D);
        preload(8'h40, 32'h0000_0000);
        preload(8'h50, 32'h0BAD_F00D);
        @(negedge clk);
        checkOutput("rst_ack",    {30'd0, bus.ack}, 32'd0);
        checkOutput("rst_mem_rd", {31'd0, bus.mem_read}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, bus.mem_write}, 32'd0);
        checkOutput("rst_addr",   bus.mem_addr, 32'd0);
        checkOutput("rst_wdata",  bus.mem_write_data, 32'd0);
        checkOutput("rst_rdata",  bus.rdata, 32'd0);
        reset = 1'b1;

        // Contention: four reads per port, grants must alternate starting at port 0.
        begin
            int rem0 = 4;
            int rem1 = 4;
            req_hold = 2'b11;
            for (int k = 0; k < 8; k++) begin
                logic [1:0] seen;
                seen = 2'b00;
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    if (bus.ack !== 2'b00) begin
                        seen = bus.ack;
                        break;
                    end
                end
                checkOutput($sformatf("rr_ack%0d", k), {30'd0, seen},
                            (k % 2 == 0) ? 32'd1 : 32'd2);
                checkOutput($sformatf("rr_data%0d", k), bus.rdata,
                            (k % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
                if (seen == 2'b01) rem0--;
                if (seen == 2'b10) rem1--;
                if (rem0 <= 0) req_hold[0] = 1'b0;
                if (rem1 <= 0) req_hold[1] = 1'b0;
                bus.req = req_hold;
            end
            bus.req = 2'b00;
        end

        // Single read by port 0 at 0xC8.
        run_access(2'b01, 2'b00, 32'h0000_00C8, 32'd0, 32'd0, 32'd0,
                   lat, rd_cyc, wr_cyc, ack_v, rd_v);
        checkOutput("rd_latency", lat, 32'd4);
        checkOutput("rd_cycles",  rd_cyc, 32'd3);
        checkOutput("rd_ack",     {30'd0, ack_v}, 32'd1);
        checkOutput("rd_data",    rd_v, 32'hDEAD_BEEF);

        // Port 1 writes 0x12345678 to 0x100; rdata must keep the old read value.
        run_access(2'b10, 2'b10, 32'd0, 32'h0000_0100, 32'd0, 32'h1234_5678,
                   lat, rd_cyc, wr_cyc, ack_v, rd_v);
        checkOutput("wr_latency", lat, 32'd2);
        checkOutput("wr_cycles",  wr_cyc, 32'd1);
        checkOutput("wr_ack",     {30'd0, ack_v}, 32'd2);
        checkOutput("wr_rdata_hold", rd_v, 32'hDEAD_BEEF);
        checkOutput("wr_mem",     mem[8'h40], 32'h1234_5678);

        // Read back the written word through port 0.
        run_access(2'b01, 2'b00, 32'h0000_0100, 32'd0, 32'd0, 32'd0,
                   lat, rd_cyc, wr_cyc, ack_v, rd_v);
        checkOutput("rb_ack",  {30'd0, ack_v}, 32'd1);
        checkOutput("rb_data", rd_v, 32'h1234_5678);

        // Reset asserted in the WR cycle before its posedge: write must not commit.
        @(negedge clk);
        applyStimulus(2'b01, 2'b01, 32'h0000_0140, 32'd0, 32'hFFFF_0000, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("ab_in_wr", {31'd0, bus.mem_write}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("ab_wr_drop", {31'd0, bus.mem_write}, 32'd0);
        checkOutput("ab_rdata",   bus.rdata, 32'd0);
        applyStimulus(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("ab_mem", mem[8'h50], 32'h0BAD_F00D);
        reset = 1'b1;
        begin
            logic [1:0] any_ack;
            logic       any_strobe;
            any_ack    = 2'b00;
            any_strobe = 1'b0;
            repeat (3) begin
                @(negedge clk);
                any_ack    = any_ack | bus.ack;
                any_strobe = any_strobe | bus.mem_read | bus.mem_write;
            end
            checkOutput("ab_no_ack",  {30'd0, any_ack}, 32'd0);
            checkOutput("ab_idle",    {31'd0, any_strobe}, 32'd0);
        end
        // FSM must be in IDLE: a fresh write completes with the normal latency.
        run_access(2'b01, 2'b01, 32'h0000_0140, 32'd0, 32'h0000_BEEF, 32'd0,
                   lat, rd_cyc, wr_cyc, ack_v, rd_v);
        checkOutput("ab_after_lat", lat, 32'd2);
        checkOutput("ab_after_mem", mem[8'h50], 32'h0000_BEEF);

        // READ_WAIT=1 instance: port 0 read of 0x14, ack two cycles after the sample.
        @(negedge clk);
        bus2.req = 2'b01;
        @(posedge clk);
        lat   = 0;
        ack_v = 2'b00;
        rd_v  = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (bus2.ack !== 2'b00) begin
                ack_v = bus2.ack;
                rd_v  = bus2.rdata;
                break;
            end
        end
        bus2.req = 2'b00;
        checkOutput("p1_latency", lat, 32'd2);
        checkOutput("p1_ack",     {30'd0, ack_v}, 32'd1);
        checkOutput("p1_data",    rd_v, 32'h5A5A_A5B1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
